// File: rtl/asc_pkg.sv
// Shared ASCII constants and FSM encoding for the decimal number parser.
// Optional build macro: SIGNED_INPUT_EN (leading '-' accepted).
package asc_pkg;

    localparam logic [7:0] ASC_0     = 8'h30;
    localparam logic [7:0] ASC_9     = 8'h39;
    localparam logic [7:0] ASC_SP    = 8'h20;
    localparam logic [7:0] ASC_CR    = 8'h0D;
    localparam logic [7:0] ASC_LF    = 8'h0A;
    localparam logic [7:0] ASC_COMMA = 8'h2C;
    localparam logic [7:0] ASC_MINUS = 8'h2D;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_EVAL,
        S_OUT
    } state_t;

endpackage

// File: rtl/asc_digit_decode.sv
// Combinational classifier for one received byte: decimal digit or delimiter.
// Optional build macro: SIGNED_INPUT_EN (no effect here).
module asc_digit_decode
    import asc_pkg::*;
(
    input  logic [7:0] i_byte,
    output logic [3:0] o_digit,
    output logic       o_is_digit,
    output logic       o_is_delim
);

    logic [7:0] diff;

    always_comb begin
        diff       = i_byte - ASC_0;
        o_is_digit = (i_byte >= ASC_0) && (i_byte <= ASC_9);
        o_digit    = o_is_digit ? diff[3:0] : 4'd0;
        o_is_delim = (i_byte == ASC_SP) || (i_byte == ASC_CR) ||
                     (i_byte == ASC_LF) || (i_byte == ASC_COMMA);
    end

endmodule

// File: rtl/asc_num_parser.sv
// Drains the RX FIFO, accumulates decimal numbers, hands them off valid/ready.
// Optional build macro: SIGNED_INPUT_EN (leading '-' gives two's complement).
module asc_num_parser
    import asc_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int MAX_DIGITS = 5
) (
    input  logic              iCLK,
    input  logic              iRST_N,
    input  logic              iFIFO_EMPTY,
    input  logic [7:0]        iFIFO_DATA,
    output logic              oFIFO_RD,
    output logic [DATA_W-1:0] oVALUE,
    output logic              oERR,
    output logic              oVALID,
    input  logic              iREADY
);

    localparam int ACC_W = DATA_W + 4;
    localparam int CNT_W = $clog2(MAX_DIGITS + 2);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_DIGITS);

`ifdef SIGNED_INPUT_EN
    localparam logic [ACC_W-1:0] LIM_POS =
        {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] LIM_NEG = LIM_POS + 1'b1;
`else
    localparam logic [ACC_W-1:0] LIM_U = {4'b0, {DATA_W{1'b1}}};
`endif

    state_t            state_q, state_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              neg_q, neg_d;
    logic              rd_q, rd_d;
    logic [DATA_W-1:0] value_q, value_d;
    logic              oerr_q, oerr_d;
    logic              valid_q, valid_d;

    logic [3:0]        dig;
    logic              is_digit;
    logic              is_delim;
    logic [ACC_W-1:0]  acc_ext;
    logic [ACC_W-1:0]  acc_nxt;
    logic [ACC_W-1:0]  lim;
    logic              bad;

    asc_digit_decode u_dec (
        .i_byte     (iFIFO_DATA),
        .o_digit    (dig),
        .o_is_digit (is_digit),
        .o_is_delim (is_delim)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        neg_d   = neg_q;
        rd_d    = 1'b0;
        value_d = value_q;
        oerr_d  = oerr_q;
        valid_d = valid_q;
        acc_ext = ACC_W'(acc_q);
        acc_nxt = (acc_ext << 3) + (acc_ext << 1) + ACC_W'(dig);
`ifdef SIGNED_INPUT_EN
        lim     = neg_q ? LIM_NEG : LIM_POS;
`else
        lim     = LIM_U;
`endif
        // A lone sign with no digits is malformed.
        bad     = err_q || (cnt_q == '0);

        unique case (state_q)
            S_IDLE: begin
                if (!iFIFO_EMPTY) begin
                    state_d = S_FETCH;
                    rd_d    = 1'b1;
                end
            end
            S_FETCH: state_d = S_EVAL;
            S_EVAL: begin
                state_d = S_IDLE;
                if (is_digit) begin
                    if (!err_q) begin
                        if (acc_nxt > lim || cnt_q >= MAX_CNT) begin
                            err_d = 1'b1;
                        end else begin
                            acc_d = acc_nxt[DATA_W-1:0];
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end else if (is_delim) begin
                    if (cnt_q != '0 || err_q || neg_q) begin
                        state_d = S_OUT;
                        valid_d = 1'b1;
                        oerr_d  = bad;
                        if (bad)
                            value_d = '0;
                        else if (neg_q)
                            value_d = ~acc_q + 1'b1;
                        else
                            value_d = acc_q;
                    end
`ifdef SIGNED_INPUT_EN
                end else if (iFIFO_DATA == ASC_MINUS &&
                             cnt_q == '0 && !neg_q && !err_q) begin
                    neg_d = 1'b1;
`endif
                end else begin
                    err_d = 1'b1;
                end
            end
            S_OUT: begin
                if (iREADY) begin
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                    acc_d   = '0;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    neg_d   = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            neg_q   <= 1'b0;
            rd_q    <= 1'b0;
            value_q <= '0;
            oerr_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            neg_q   <= neg_d;
            rd_q    <= rd_d;
            value_q <= value_d;
            oerr_q  <= oerr_d;
            valid_q <= valid_d;
        end
    end

    assign oFIFO_RD = rd_q;
    assign oVALUE   = value_q;
    assign oERR     = oerr_q;
    assign oVALID   = valid_q;

endmodule

// File: tb/tb_asc_num_parser.sv
// Scoreboard bench for asc_num_parser: FIFO model, expected-result queue.
// Optional build macro: SIGNED_INPUT_EN (switches expected results).
module tb_asc_num_parser;

    logic        iCLK = 1'b0;
    logic        iRST_N = 1'b0;
    logic        iFIFO_EMPTY = 1'b1;
    logic [7:0]  iFIFO_DATA = 8'h00;
    logic        oFIFO_RD;
    logic [15:0] oVALUE;
    logic        oERR;
    logic        oVALID;
    logic        iREADY = 1'b0;

    typedef struct {
        logic [15:0] v;
        logic        e;
    } exp_t;

    byte  fifo_q[$];
    exp_t sb_q[$];
    int   n_chk = 0;
    int   n_pass = 0;
    int   cyc = 0;
    int   rd_cnt = 0;
    int   last_rd = 0;
    logic prev_valid = 1'b0;

    always #5 iCLK = ~iCLK;

    asc_num_parser #(.DATA_W(16), .MAX_DIGITS(5)) dut (
        .iCLK        (iCLK),
        .iRST_N      (iRST_N),
        .iFIFO_EMPTY (iFIFO_EMPTY),
        .iFIFO_DATA  (iFIFO_DATA),
        .oFIFO_RD    (oFIFO_RD),
        .oVALUE      (oVALUE),
        .oERR        (oERR),
        .oVALID      (oVALID),
        .iREADY      (iREADY)
    );

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick(int n);
        repeat (n) @(posedge iCLK);
        #1;
    endtask

    task automatic send(string s);
        for (int i = 0; i < s.len(); i++) fifo_q.push_back(s[i]);
    endtask

    task automatic expect_out(logic [15:0] v, logic e);
        exp_t x;
        x.v = v;
        x.e = e;
        sb_q.push_back(x);
    endtask

    task automatic drain(string tag);
        int i;
        for (i = 0; i < 400; i++) begin
            tick(1);
            if (fifo_q.size() == 0 && sb_q.size() == 0) break;
        end
        chk(tag, 32'(i < 400), 32'd1);
        tick(4);
    endtask

    // FIFO model and output monitor, both away from the active edge.
    always @(negedge iCLK) begin
        exp_t x;
        cyc++;
        if (iRST_N) begin
            if (oFIFO_RD) begin
                chk("rd_nonempty", 32'(fifo_q.size() != 0), 32'd1);
                if (fifo_q.size() != 0) iFIFO_DATA = fifo_q.pop_front();
                rd_cnt++;
                last_rd = cyc;
            end
            if (oVALID && !prev_valid)
                chk("valid_latency", 32'(cyc - last_rd), 32'd2);
            if (oVALID && iREADY) begin
                chk("sb_has_entry", 32'(sb_q.size() != 0), 32'd1);
                if (sb_q.size() != 0) begin
                    x = sb_q.pop_front();
                    chk("value", 32'(oVALUE), 32'(x.v));
                    chk("err", 32'(oERR), 32'(x.e));
                end
            end
        end
        prev_valid  = oVALID;
        iFIFO_EMPTY = (fifo_q.size() == 0);
    end

    initial begin
        int r;
        int i;
        iREADY = 1'b1;
        tick(3);
        chk("rst_valid", 32'(oVALID), 0);
        chk("rst_rd", 32'(oFIFO_RD), 0);
        chk("rst_value", 32'(oVALUE), 0);
        chk("rst_err", 32'(oERR), 0);
        iRST_N = 1'b1;
        tick(2);

        r = rd_cnt;
        send("123 ");
        expect_out(16'd123, 1'b0);
        drain("drain_123");
        chk("rd_pulses_123", 32'(rd_cnt - r), 32'd4);

        send("65535\n65536 ");
`ifdef SIGNED_INPUT_EN
        expect_out(16'd0, 1'b1);
`else
        expect_out(16'd65535, 1'b0);
`endif
        expect_out(16'd0, 1'b1);
        drain("drain_max");

        send("  1a2,7,");
        expect_out(16'd0, 1'b1);
        expect_out(16'd7, 1'b0);
        drain("drain_illegal");

        send(",,\r\n00012 123456 0 ");
        expect_out(16'd12, 1'b0);
        expect_out(16'd0, 1'b1);
        expect_out(16'd0, 1'b0);
        drain("drain_digits");

        iREADY = 1'b0;
        send("42 9 ");
        expect_out(16'd42, 1'b0);
        expect_out(16'd9, 1'b0);
        for (i = 0; i < 100 && !oVALID; i++) tick(1);
        chk("hold_seen", 32'(oVALID), 32'd1);
        r = rd_cnt;
        tick(20);
        chk("hold_valid", 32'(oVALID), 32'd1);
        chk("hold_value", 32'(oVALUE), 32'd42);
        chk("hold_no_rd", 32'(rd_cnt - r), 32'd0);
        iREADY = 1'b1;
        drain("drain_hold");

        send("98");
        for (i = 0; i < 100 && fifo_q.size() != 0; i++) tick(1);
        tick(4);
        iRST_N = 1'b0;
        #2;
        chk("mid_rst_valid", 32'(oVALID), 0);
        chk("mid_rst_rd", 32'(oFIFO_RD), 0);
        chk("mid_rst_value", 32'(oVALUE), 0);
        chk("mid_rst_err", 32'(oERR), 0);
        tick(2);
        iRST_N = 1'b1;
        tick(1);
        send("5 ");
        expect_out(16'd5, 1'b0);
        drain("drain_after_rst");

        send("-32768 -5 -32769 - 5-3 --1 ");
`ifdef SIGNED_INPUT_EN
        expect_out(16'h8000, 1'b0);
        expect_out(16'hFFFB, 1'b0);
`else
        expect_out(16'd0, 1'b1);
        expect_out(16'd0, 1'b1);
`endif
        expect_out(16'd0, 1'b1);
        expect_out(16'd0, 1'b1);
        expect_out(16'd0, 1'b1);
        expect_out(16'd0, 1'b1);
        drain("drain_minus");

        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/asc_num_parser.md
Name: asc_num_parser

Overview:
Sequencing controller for the ASCII digit path. It drains ASCII characters from the UART receive FIFO one byte at a time and decodes each byte as a decimal digit. It accumulates multi-digit decimal numbers terminated by a delimiter, then presents each completed number to the downstream consumer with a valid/ready handshake. It sits between the RX FIFO and the command/arithmetic logic and owns the FIFO read strobe.

Parameters:
DATA_W, 16, width of the accumulated unsigned result.
MAX_DIGITS, 5, maximum digits per number; more digits is an error.

Ports:
iCLK  in  1  system clock
iRST_N  in  1  asynchronous active-low reset
iFIFO_EMPTY  in  1  RX FIFO empty flag
iFIFO_DATA  in  8  FIFO read data, valid the cycle after oFIFO_RD (normal, non-show-ahead mode)
oFIFO_RD  out  1  FIFO read strobe, one cycle per character
oVALUE  out  DATA_W  parsed number
oERR  out  1  number was malformed or overflowed; qualified by oVALID
oVALID  out  1  oVALUE/oERR valid
iREADY  in  1  consumer accepts the number

Behaviour:
- Reset: asynchronous, active-low. All outputs are 0, state is IDLE, and the accumulator, digit count and error flag are cleared. Reset during any state discards the partial number; bytes already read from the FIFO are lost.
- FSM states: IDLE, FETCH, EVAL, OUT.
- IDLE: if iFIFO_EMPTY = 0, go to FETCH; otherwise stay in IDLE.
- FETCH: oFIFO_RD = 1 for exactly this cycle, then go to EVAL. oFIFO_RD is never asserted in any other state, and never while iFIFO_EMPTY = 1.
- EVAL: samples iFIFO_DATA and classifies the byte:
  - Digit 0x30-0x39: acc = acc*10 + d, computed in DATA_W+4 bits; cnt++.
    - If the result exceeds 2^DATA_W-1, or cnt would exceed MAX_DIGITS, set the sticky err and stop updating acc.
    - Next state: IDLE.
  - Delimiter 0x20, 0x0D, 0x0A or 0x2C:
    - If cnt = 0 and err = 0, ignore it (leading or repeated delimiters) and go to IDLE.
    - Otherwise go to OUT.
  - Any other byte: set sticky err; continue consuming bytes until the next delimiter. Next state: IDLE.
- OUT: registered outputs.
  - oVALID = 1; oVALUE = acc, or 0 if err; oERR = err.
  - Values are held stable until iREADY = 1.
  - On the cycle oVALID and iREADY are both 1: clear acc, cnt and err; go to IDLE. oVALID deasserts in the following cycle.
  - No FIFO reads occur while in OUT (backpressure halts draining).
- Throughput: one character per 3 cycles (IDLE, FETCH, EVAL). Latency from the delimiter's EVAL cycle to oVALID is 1 cycle.
- iFIFO_EMPTY rising while in FETCH/EVAL has no effect; the outstanding read completes.
- A number spanning a FIFO-empty gap is accumulated correctly. No timeout applies.

Optional Feature:
SIGNED_INPUT_EN
- Defined: a 0x2D ('-') received while cnt = 0 and the number is not yet started sets a neg flag. On delimiter, oVALUE = two's complement of acc.
  - The range check becomes magnitude ≤ 2^(DATA_W-1) when neg, and ≤ 2^(DATA_W-1)-1 otherwise.
  - A '-' after any digit, or a second '-', is an error.
  - A lone '-' followed by a delimiter gives oERR = 1.
- Not defined: '-' is an ordinary illegal byte (sets err). The unsigned range is used.

Decomposition:
- Package asc_pkg: ASCII constants (ASC_0, ASC_9, ASC_SP, ASC_CR, ASC_LF, ASC_COMMA, ASC_MINUS) and the FSM state encoding.
- Sub-module asc_digit_decode (combinational): byte in; outputs 4-bit digit, is_digit, is_delim. Instantiated once in EVAL's datapath.
- Accumulate, range check and FSM live in the top.

Test Plan:
- "123 " into FIFO, iREADY = 1 → exactly 4 oFIFO_RD pulses; oVALID with oVALUE = 123, oERR = 0; oVALID 1 cycle after the space's EVAL.
- "65535\n" then "65536 " → first oVALUE = 65535, oERR = 0; second oERR = 1, oVALUE = 0 (DATA_W = 16).
- "  1a2,7," → leading spaces produce no output; outputs are oERR = 1 (value 0), then oVALUE = 7.
- "42 9 " with iREADY held 0 for 20 cycles → oVALID/oVALUE = 42 stable; no oFIFO_RD during the hold; 9 follows after acceptance.
- iRST_N pulsed low after "98" is consumed, then "5 " → oVALUE = 5, not 985; all outputs 0 during reset.
- With SIGNED_INPUT_EN: "-32768 -5 -32769 " → oVALUE = 0x8000, then 0xFFFB, then oERR = 1.
